// File: rtl/aes_pkg.sv
// Shared AES decryption types, FSM encoding, inverse S-box table and byte-offset helper.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte 0 occupies the MSBs of the state.
    function automatic logic [6:0] byte_idx(input logic [3:0] k);
        return 7'd127 - {k, 3'b000};
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Upstream (ShiftRows) and downstream (AddRoundKey) valid/ready handshakes of inv_sub_bytes_seq.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES inverse SubBytes: BYTES_PER_CYCLE shared S-boxes walk a 16-byte work register.
// Optional block counter output enabled by INV_SUB_BYTES_SEQ_PERF_EN.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    inv_sub_bytes_seq_if.slave bus,
`ifdef INV_SUB_BYTES_SEQ_PERF_EN
    output logic [31:0]        blk_count,
`endif
    output logic               busy
);

    localparam int unsigned NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           work_q, work_d;
    logic [3:0]       chunk_base;
    byte_t            sbox_in  [BYTES_PER_CYCLE];
    byte_t            sbox_out [BYTES_PER_CYCLE];

    assign chunk_base = 4'(32'(cnt_q) * BYTES_PER_CYCLE);

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (sbox_in[g]),
            .out_byte (sbox_out[g])
        );
    end

    always_comb begin
        for (int unsigned g = 0; g < BYTES_PER_CYCLE; g++) begin
            sbox_in[g] = work_q[byte_idx(chunk_base + 4'(g)) -: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned g = 0; g < BYTES_PER_CYCLE; g++) begin
                    work_d[byte_idx(chunk_base + 4'(g)) -: 8] = sbox_out[g];
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign bus.out_state = work_q;
    assign busy          = (state_q != StIdle);

`ifdef INV_SUB_BYTES_SEQ_PERF_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (state_q == StDone && bus.out_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Iterative AES inverse SubBytes stage that sits directly downstream of the inverse ShiftRows stage in the decryption datapath.
- Accepts a 128-bit state over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through shared inverse S-box instances.
- Presents the result to the next stage (AddRoundKey) over a second valid/ready handshake.
- Trades latency for S-box area.

Parameters:
BYTES_PER_CYCLE, 4, bytes substituted per RUN cycle. Legal values are 1, 2, 4, 8, 16. Any other value is an elaboration error.
NCHUNK, 16/BYTES_PER_CYCLE, derived localparam: RUN cycles per block.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream state valid
in_ready  out  1  block can accept a state
in_state  in  128  input state; byte k = in_state[127-8k -: 8], column-major (byte 0 = row0/col0, byte 1 = row1/col0, ...)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_state  out  128  substituted state, same byte packing
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; chunk counter = 0; work register = 0.
  - Outputs: out_valid=0, out_state=0, busy=0, in_ready=1 after the edge.
  - Reset mid-RUN or mid-DONE discards the block; no output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, capture in_state into the work register, clear the counter, go to RUN.
  - RUN: in_ready=0. Each cycle, replace work bytes [cnt*B .. cnt*B+B-1] with InvSbox(byte), then cnt++. On the cycle with cnt==NCHUNK-1, go to DONE.
  - DONE: out_valid=1, out_state=work register. On out_ready=1, go to IDLE with out_valid=0 after the edge. Otherwise hold state and out_state stable.
- Latency: out_valid rises NCHUNK clocks after the accept edge (4 at the default B).
- Throughput: one block per NCHUNK+2 clocks when out_ready is held high.
- in_ready depends only on state, never combinationally on in_valid or out_ready.
- out_state is registered and driven directly from the work register, so there is no combinational path from inputs to outputs.
- in_valid is ignored outside IDLE; upstream must hold data until in_ready. in_state is sampled only on the accept edge.
- Bytes are processed in order 0..15, i.e. MSB byte first.
- BYTES_PER_CYCLE=16: a single RUN cycle substitutes all 16 bytes.
- Counter width is clog2(NCHUNK), minimum 1 bit. Counter wrap is impossible because the FSM leaves RUN at NCHUNK-1.

Optional Feature:
Macro INV_SUB_BYTES_SEQ_PERF_EN.
- Defined: adds output port blk_count [31:0].
  - Reset value 0.
  - Increments by 1 on each DONE->IDLE handshake (out_valid & out_ready).
  - Wraps from 0xFFFFFFFF to 0.
  - A reset mid-block does not count.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - byte/state typedefs;
  - the 256-entry inverse S-box constant table;
  - function byte_idx(k) returning the bit offset 127-8k.
- One natural sub-module, inv_sbox: combinational 8-bit to 8-bit lookup from the package table. It is instantiated BYTES_PER_CYCLE times with a generate loop.
- FSM, counter and work register live in the top module.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 clks -> out_valid=0, out_state=0, busy=0, in_ready=1.
2. All-zero state 0x000...0, out_ready=1:
   - in_ready=0 during the 4 RUN clks;
   - out_valid high exactly 4 clks after accept;
   - out_state = 0x5252...52;
   - returns to IDLE the next clk.
3. FIPS-197 C.1 round[1]: in_state 0x7a9f102789d5f50b2beffd9f3dca4ea7 -> out_state 0xbd6e7c3df2b5779e0b61216e8b10b689.
4. Backpressure: in_state 0x637c63ff... pattern with out_ready=0 for 10 clks:
   - out_valid and out_state (0x0001007d...) held stable throughout;
   - in_valid pulses are ignored;
   - out_ready=1 completes exactly one transfer.
5. Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle -> next clk IDLE, out_valid=0, work register=0, no output ever produced for that block.
6. Parameter sweep B=1,2,8,16 with vector 3: latency equals 16, 8, 2, 1 clks respectively and results are identical. With PERF_EN defined, blk_count=4 after four completed blocks.
